// File: rtl/ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ce_sequencer
// Brief    : Clock-enable sequencer on clk24: master-counter decodes,
//            programmable divider channels, optional fractional-rate enable
//            (build with CE_FRAC_EN defined to include the accumulator).
// Revision : 1.0
// ============================================================================
module ce_sequencer #(
    parameter int CTR_W       = 6,
    parameter int NCH         = 4,
    parameter int INIT_DLY    = 3,
    parameter int PHACC_W     = 32,
    parameter int PHACC_DELTA = 253896634
) (
    input  logic             clk24,
    input  logic             reset_n,
    input  logic             run,
    input  logic             turbo,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [CTR_W-1:0] cfg_div,
    input  logic [CTR_W-1:0] cfg_phase,
    output logic             ce12,
    output logic             ce6,
    output logic             ce3,
    output logic             ce3v,
    output logic             ce1m5,
    output logic             video_slice,
    output logic             pipe_ab,
    output logic [NCH-1:0]   ce_ch,
    output logic             ce_frac,
    output logic             ready,
    output logic [CTR_W-1:0] ctr_out
);

    logic [4:0]       r_initctr;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] r_div  [NCH];
    logic [CTR_W-1:0] r_dcnt [NCH];
    logic             w_adv;

    assign w_adv   = ready & run;
    assign ctr_out = r_ctr;

    // Decodes are taken from the pre-increment counter, so each output
    // reflects the ctr value of the previous clock.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_initctr   <= '0;
            ready       <= 1'b0;
            r_ctr       <= '0;
            ce12        <= 1'b0;
            ce6         <= 1'b0;
            ce3         <= 1'b0;
            ce3v        <= 1'b0;
            ce1m5       <= 1'b0;
            video_slice <= 1'b0;
            pipe_ab     <= 1'b0;
        end else begin
            if (!ready) begin
                if (r_initctr == 5'(INIT_DLY))
                    ready <= 1'b1;
                else
                    r_initctr <= r_initctr + 5'd1;
            end
            if (w_adv) begin
                r_ctr       <= r_ctr + 1'b1;
                ce12        <= r_ctr[0];
                ce6         <= (r_ctr[1:0] == 2'd3);
                ce3         <= (r_ctr[2:0] == 3'd5) || (turbo && (r_ctr[2:0] == 3'd1));
                ce3v        <= (r_ctr[2:0] == 3'd6);
                ce1m5       <= (r_ctr[3:0] == 4'd13);
                video_slice <= ~r_ctr[2];
                pipe_ab     <= r_ctr[CTR_W-1];
            end else begin
                ce12  <= 1'b0;
                ce6   <= 1'b0;
                ce3   <= 1'b0;
                ce3v  <= 1'b0;
                ce1m5 <= 1'b0;
            end
        end
    end

    // Matching cfg_ch against each in-range index drops writes to absent channels.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            ce_ch <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_div[i]  <= '1;
                r_dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    r_div[i]  <= cfg_div;
                    r_dcnt[i] <= cfg_phase;
                    ce_ch[i]  <= 1'b0;
                end else if (w_adv) begin
                    if (r_dcnt[i] == '0) begin
                        ce_ch[i]  <= 1'b1;
                        r_dcnt[i] <= r_div[i];
                    end else begin
                        ce_ch[i]  <= 1'b0;
                        r_dcnt[i] <= r_dcnt[i] - 1'b1;
                    end
                end else begin
                    ce_ch[i] <= 1'b0;
                end
            end
        end
    end

`ifdef CE_FRAC_EN
    localparam logic [PHACC_W-1:0] C_DELTA = PHACC_W'(PHACC_DELTA);

    logic [PHACC_W-1:0] r_acc;
    logic [PHACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, C_DELTA};

    // Runs from ready regardless of run; a carry out marks one fractional tick.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            ce_frac <= 1'b0;
        end else if (ready) begin
            r_acc   <= w_sum[PHACC_W-1:0];
            ce_frac <= w_sum[PHACC_W];
        end else begin
            ce_frac <= 1'b0;
        end
    end
`else
    assign ce_frac = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ce_sequencer
// Brief    : Directed self-checking bench for ce_sequencer (default params).
// Revision : 1.0
// ============================================================================
module tb_ce_sequencer;

    logic       clk24 = 1'b0;
    logic       reset_n, run, turbo, cfg_we;
    logic [2:0] cfg_ch;
    logic [5:0] cfg_div, cfg_phase;
    logic       ce12, ce6, ce3, ce3v, ce1m5, video_slice, pipe_ab, ce_frac, ready;
    logic [3:0] ce_ch;
    logic [5:0] ctr_out;

    int n_chk = 0;
    int n_err = 0;

    ce_sequencer dut (
        .clk24(clk24), .reset_n(reset_n), .run(run), .turbo(turbo),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .ce12(ce12), .ce6(ce6), .ce3(ce3), .ce3v(ce3v), .ce1m5(ce1m5),
        .video_slice(video_slice), .pipe_ab(pipe_ab), .ce_ch(ce_ch),
        .ce_frac(ce_frac), .ready(ready), .ctr_out(ctr_out)
    );

    always #5 clk24 = ~clk24;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk24);
        #1;
    endtask

    task automatic wait_ctr(input logic [5:0] val, input string tag);
        int n = 0;
        while (ctr_out != val && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(ctr_out == val), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, 4);
    endtask

    // Clocks from one pulse of the chosen channel to the next.
    task automatic ch_gap(input int ch, input string tag, input int exp);
        int n = 0;
        while (!ce_ch[ch] && n < 200) tick();
        do begin
            tick();
            n++;
        end while (!ce_ch[ch] && n < 200);
        chk(tag, n, exp);
    endtask

    int c12, c6, c3, c3v, c15, ctog, cch0, cpulse, c1, c0, c3ch;
    logic prev_pipe;

    initial begin
        reset_n = 1'b0; run = 1'b0; turbo = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_ctr", 32'(ctr_out), 0);
        chk("rst_pulses", 32'({ce12, ce6, ce3, ce3v, ce1m5, ce_ch, ce_frac}), 0);

        // Startup delay, then first ce12 two clocks after ready.
        reset_n = 1'b1; run = 1'b1;
        wait_ready("ready_delay");
        tick();
        chk("ce12_first_lo", 32'(ce12), 0);
        tick();
        chk("ce12_first_hi", 32'(ce12), 1);
        chk("ctr_after_first", 32'(ctr_out), 2);

        // One full counter period of decodes.
        c12 = 0; c6 = 0; c3 = 0; c3v = 0; c15 = 0; ctog = 0; cch0 = 0;
        prev_pipe = pipe_ab;
        for (int i = 0; i < 64; i++) begin
            tick();
            c12 += ce12; c6 += ce6; c3 += ce3; c3v += ce3v; c15 += ce1m5; cch0 += ce_ch[0];
            if (pipe_ab != prev_pipe) ctog++;
            prev_pipe = pipe_ab;
        end
        chk("cnt_ce12", c12, 32);
        chk("cnt_ce6", c6, 16);
        chk("cnt_ce3", c3, 8);
        chk("cnt_ce3v", c3v, 8);
        chk("cnt_ce1m5", c15, 4);
        chk("pipe_toggles", ctog, 2);
        chk("cnt_ch0_default", cch0, 1);

        turbo = 1'b1;
        c3 = 0; c3v = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            c3 += ce3; c3v += ce3v;
        end
        chk("cnt_ce3_turbo", c3, 16);
        chk("cnt_ce3v_turbo", c3v, 8);
        turbo = 1'b0;

        // Pause at ctr=20: last decode came from 19, so video_slice holds 1.
        wait_ctr(6'd20, "reach_ctr20");
        run = 1'b0;
        cpulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cpulse += ce12 + ce6 + ce3 + ce3v + ce1m5 + (ce_ch != 0);
        end
        chk("pause_pulses", cpulse, 0);
        chk("pause_ctr", 32'(ctr_out), 20);
        chk("pause_vslice", 32'(video_slice), 1);
        run = 1'b1;
        tick();
        chk("resume_ctr", 32'(ctr_out), 21);
        chk("resume_vslice", 32'(video_slice), 0);
        tick();
        chk("resume_ce12", 32'(ce12), 1);

        // Channel 2: divide 4, phase 1.
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 6'd4; cfg_phase = 6'd1;
        tick();
        cfg_we = 1'b0;
        chk("ch2_write_clk", 32'(ce_ch[2]), 0);
        tick();
        chk("ch2_plus1", 32'(ce_ch[2]), 0);
        tick();
        chk("ch2_plus2", 32'(ce_ch[2]), 1);
        ch_gap(2, "ch2_period_a", 5);
        ch_gap(2, "ch2_period_b", 5);

        // Out-of-range write must not touch any channel.
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 6'd0; cfg_phase = 6'd0;
        tick();
        cfg_we = 1'b0;
        c0 = 0; c1 = 0; c3ch = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            c0 += ce_ch[0]; c1 += ce_ch[1]; c3ch += ce_ch[3];
        end
        chk("oor_ch0", 32'(c0 <= 1), 1);
        chk("oor_ch1", 32'(c1 <= 1), 1);
        chk("oor_ch3", 32'(c3ch <= 1), 1);
        ch_gap(2, "oor_ch2_period", 5);
        chk("no_frac", 32'(ce_frac), 0);

        // Mid-run reset: outputs reflecting ctr=37 clear without a clock edge.
        wait_ctr(6'd38, "reach_ctr38");
        chk("pre_rst_ce12", 32'(ce12), 1);
        chk("pre_rst_ce3", 32'(ce3), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_ce12", 32'(ce12), 0);
        chk("async_ce3", 32'(ce3), 0);
        chk("async_ready", 32'(ready), 0);
        chk("async_ctr", 32'(ctr_out), 0);
        tick();
        reset_n = 1'b1;
        wait_ready("ready_delay_rerun");
        ch_gap(0, "ch0_period_reset", 64);
        ch_gap(2, "ch2_period_reset", 64);

`ifdef CE_FRAC_EN
        c0 = 0;
        for (int i = 0; i < (1 << 20); i++) begin
            @(posedge clk24);
            #1;
            c0 += ce_frac;
        end
        chk("frac_count", 32'((c0 >= 61985) && (c0 <= 61987)), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
